dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory between the processor's load/store port (m0) and a second bus master (m1, a loader/DMA engine). It sits between the requesters and the data memory and drives the memory's write enable, address and write data from whichever master owns the memory. It registers read data back to the owner. Ownership is tracked by a small FSM with round-robin tie-breaking and a burst limit so neither master is starved.

---
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/dmem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data memory arbiter: one instance per master.
// The master modport belongs to the requester and the slave modport to the arbiter.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rdata, rvalid
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the load/store port (m0) and a loader/DMA master (m1).
// Default is round robin with a MAX_BURST limit; define DMEM_ARB_FIXED_PRIO_EN for fixed m0 priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              access0;
  logic              access1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid0;
  logic              rvalid1;

  assign m0.gnt    = (state == OWN0);
  assign m1.gnt    = (state == OWN1);
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;

  // Gating with rst keeps a write from landing in the cycle reset is asserted.
  assign access0 = (state == OWN0) && m0.req && rst;
  assign access1 = (state == OWN1) && m1.req && rst;

`ifdef DMEM_ARB_FIXED_PRIO_EN

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0.req) begin
          state_next = OWN0;
        end else if (m1.req) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!m0.req) begin
          state_next = m1.req ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (m0.req) begin
          state_next = OWN0;
        end else if (!m1.req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`else

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_next;
  logic [CNT_W-1:0] burst_inc;
  logic             burst_done;
  logic             last;
  logic             last_next;

  assign burst_inc  = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);
  // >= so that a counter saturated during a solo burst still yields to a late requester.
  assign burst_done = (burst_cnt >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last      <= 1'b1;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      last      <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0.req && m1.req) begin
          state_next = last ? OWN0 : OWN1;
        end else if (m0.req) begin
          state_next = OWN0;
        end else if (m1.req) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (m0.req) begin
          burst_next = burst_inc;
          if (burst_done && m1.req) begin
            state_next = OWN1;
            burst_next = '0;
            last_next  = 1'b0;
          end
        end else begin
          state_next = m1.req ? OWN1 : IDLE;
          burst_next = '0;
          last_next  = 1'b0;
        end
      end
      OWN1: begin
        if (m1.req) begin
          burst_next = burst_inc;
          if (burst_done && m0.req) begin
            state_next = OWN0;
            burst_next = '0;
            last_next  = 1'b1;
          end
        end else begin
          state_next = m0.req ? OWN0 : IDLE;
          burst_next = '0;
          last_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        burst_next = '0;
      end
    endcase
  end

`endif

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (access0) begin
      mem_wr_en   = m0.we;
      mem_addr    = m0.addr;
      mem_wr_data = m0.wdata;
    end else if (access1) begin
      mem_wr_en   = m1.we;
      mem_addr    = m1.addr;
      mem_wr_data = m1.wdata;
    end
  end

  // Read data is only captured for the owner; the other master's rdata holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= access0 && !m0.we;
      rvalid1 <= access1 && !m1.we;
      if (access0 && !m0.we) begin
        rdata0 <= mem_rd_data;
      end
      if (access1 && !m1.we) begin
        rdata1 <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a word-addressed memory model behind the arbiter.
// Memory word i starts out as 32'hA500_0000 | i so reads have known contents.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_init = 1'b1;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= 32'hA500_0000 | i;
      end
    end else if (mem_wr_en) begin
      mem[mem_addr[9:2]] <= mem_wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    m0_bus.req   = req;
    m0_bus.we    = we;
    m0_bus.addr  = addr;
    m0_bus.wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    m1_bus.req   = req;
    m1_bus.we    = we;
    m1_bus.addr  = addr;
    m1_bus.wdata = wdata;
  endtask

  task automatic test_reset();
    set_m0(1'b1, 1'b1, 32'h100, 32'h1111_1111);
    set_m1(1'b1, 1'b1, 32'h104, 32'h2222_2222);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid, mem_wr_en} !== 5'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: gnt/rvalid/wr_en got %b expected 00000", i,
                 {m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid, mem_wr_en});
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m0_bus.gnt, m1_bus.gnt, mem_wr_en} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: gnt0/gnt1/wr_en got %b expected 000", {m0_bus.gnt, m1_bus.gnt, mem_wr_en});
    end
    tick();
    checks++;
    if ({m0_bus.gnt, m1_bus.gnt} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_first_tie: gnt0/gnt1 got %b expected 10", {m0_bus.gnt, m1_bus.gnt});
    end
    checks++;
    if (mem_wr_en !== 1'b1 || mem_addr !== 32'h100 || mem_wr_data !== 32'h1111_1111) begin
      errors++;
      $display("[TB] FAIL reset_first_access: wr_en %b addr %h data %h expected 1 00000100 11111111",
               mem_wr_en, mem_addr, mem_wr_data);
    end
    tick();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    checks++;
    if (m0_bus.gnt !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_drop_req: gnt0 %b wr_en %b expected 1 0", m0_bus.gnt, mem_wr_en);
    end
    tick();
    checks++;
    if ({m0_bus.gnt, m1_bus.gnt} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_back_idle: gnt0/gnt1 got %b expected 00", {m0_bus.gnt, m1_bus.gnt});
    end
  endtask

  task automatic test_single_master();
    set_m1(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (m1_bus.gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_no_gnt_yet: gnt1 got %b expected 0", m1_bus.gnt);
    end
    tick();
    checks++;
    if ({m0_bus.gnt, m1_bus.gnt} !== 2'b01 || mem_wr_en !== 1'b1 || mem_addr !== 32'h40 || mem_wr_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL single_write: gnt %b wr_en %b addr %h data %h expected 01 1 00000040 deadbeef",
               {m0_bus.gnt, m1_bus.gnt}, mem_wr_en, mem_addr, mem_wr_data);
    end
    tick();
    set_m1(1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 32'h40) begin
      errors++;
      $display("[TB] FAIL single_read_access: wr_en %b addr %h expected 0 00000040", mem_wr_en, mem_addr);
    end
    tick();
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (m1_bus.rvalid !== 1'b1 || m1_bus.rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL single_rdata: rvalid1 %b rdata1 %h expected 1 deadbeef", m1_bus.rvalid, m1_bus.rdata);
    end
    checks++;
    if (m0_bus.rvalid !== 1'b0 || m0_bus.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL single_m0_untouched: rvalid0 %b rdata0 %h expected 0 00000000", m0_bus.rvalid, m0_bus.rdata);
    end
    tick();
    checks++;
    if (m1_bus.rvalid !== 1'b0 || m1_bus.rdata !== 32'hDEAD_BEEF || m1_bus.gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_rvalid_pulse: rvalid1 %b rdata1 %h gnt1 %b expected 0 deadbeef 0",
               m1_bus.rvalid, m1_bus.rdata, m1_bus.gnt);
    end
  endtask

  task automatic test_burst_limit();
    logic       exp_g0;
    logic       exp_g1;
    logic       exp_v0;
    logic       exp_v1;
    set_m0(1'b1, 1'b0, 32'h80, 32'h0);
    set_m1(1'b1, 1'b0, 32'h84, 32'h0);
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        tick();
      end else begin
        #1;
      end
      exp_g0 = (i >= 1 && i <= 4) || (i >= 9);
      exp_g1 = (i >= 5 && i <= 8);
      exp_v0 = (i >= 2 && i <= 5) || (i >= 10);
      exp_v1 = (i >= 6 && i <= 9);
      checks++;
      if ({m0_bus.gnt, m1_bus.gnt} !== {exp_g0, exp_g1}) begin
        errors++;
        $display("[TB] FAIL burst_gnt cycle %0d: gnt0/gnt1 got %b expected %b", i,
                 {m0_bus.gnt, m1_bus.gnt}, {exp_g0, exp_g1});
      end
      checks++;
      if ({m0_bus.rvalid, m1_bus.rvalid} !== {exp_v0, exp_v1}) begin
        errors++;
        $display("[TB] FAIL burst_rvalid cycle %0d: rvalid0/rvalid1 got %b expected %b", i,
                 {m0_bus.rvalid, m1_bus.rvalid}, {exp_v0, exp_v1});
      end
      if (i == 6) begin
        checks++;
        if (m0_bus.rdata !== 32'hA500_0020 || m1_bus.rdata !== 32'hA500_0021) begin
          errors++;
          $display("[TB] FAIL burst_rdata: rdata0 %h rdata1 %h expected a5000020 a5000021", m0_bus.rdata, m1_bus.rdata);
        end
      end
    end
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
  endtask

  task automatic test_release_handoff();
    set_m0(1'b1, 1'b1, 32'h90, 32'h0BAD_F00D);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++;
      if ({m0_bus.gnt, m1_bus.gnt, mem_wr_en} !== 3'b101) begin
        errors++;
        $display("[TB] FAIL release_own0 cycle %0d: gnt0/gnt1/wr_en got %b expected 101", c,
                 {m0_bus.gnt, m1_bus.gnt, mem_wr_en});
      end
    end
    tick();
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b1, 1'b0, 32'h90, 32'h0);
    #1;
    checks++;
    if (m0_bus.gnt !== 1'b1 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_cycle5: gnt0 %b wr_en %b expected 1 0", m0_bus.gnt, mem_wr_en);
    end
    tick();
    checks++;
    if ({m0_bus.gnt, m1_bus.gnt} !== 2'b01 || mem_addr !== 32'h90) begin
      errors++;
      $display("[TB] FAIL release_cycle6: gnt %b addr %h expected 01 00000090", {m0_bus.gnt, m1_bus.gnt}, mem_addr);
    end
    tick();
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (m1_bus.rvalid !== 1'b1 || m1_bus.rdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("[TB] FAIL release_readback: rvalid1 %b rdata1 %h expected 1 0badf00d", m1_bus.rvalid, m1_bus.rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    set_m1(1'b1, 1'b1, 32'h44, 32'h55AA_55AA);
    tick();
    checks++;
    if (m1_bus.gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_gnt: gnt1 got %b expected 1", m1_bus.gnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 32'h0 || mem_wr_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_mem_forced: wr_en %b addr %h data %h expected 0 00000000 00000000",
               mem_wr_en, mem_addr, mem_wr_data);
    end
    tick();
    checks++;
    if (mem[32'h11] !== 32'hA500_0011) begin
      errors++;
      $display("[TB] FAIL midreset_mem_unchanged: word got %h expected a5000011", mem[32'h11]);
    end
    checks++;
    if ({m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid} !== 4'b0 || m0_bus.rdata !== 32'h0 || m1_bus.rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: gnt/rvalid %b rdata0 %h rdata1 %h expected 0000 00000000 00000000",
               {m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid}, m0_bus.rdata, m1_bus.rdata);
    end
    rst = 1'b1;
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_fixed_prio();
    set_m1(1'b1, 1'b0, 32'h84, 32'h0);
    tick();
    set_m0(1'b1, 1'b0, 32'h80, 32'h0);
    #1;
    checks++;
    if ({m0_bus.gnt, m1_bus.gnt} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL fixed_m1_owns: gnt %b expected 01", {m0_bus.gnt, m1_bus.gnt});
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({m0_bus.gnt, m1_bus.gnt} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL fixed_m0_holds cycle %0d: gnt %b expected 10", c, {m0_bus.gnt, m1_bus.gnt});
      end
    end
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
  endtask

  initial begin
    set_m0(1'b0, 1'b0, 32'h0, 32'h0);
    set_m1(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    mem_init = 1'b0;
    test_reset();
    test_single_master();
`ifndef DMEM_ARB_FIXED_PRIO_EN
    test_burst_limit();
`endif
    test_release_handoff();
    test_reset_mid_write();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
